// File: rtl/my_mul5_seq.sv
// rtl/my_mul5_seq.sv - 5x5 unsigned shift-add sequential multiplier
module my_mul5_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] Ain,
  input  logic [4:0] Bin,
  output logic [9:0] Pout,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  m_q, m_d;
  logic [4:0]  q_q, q_d;
  logic [4:0]  acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  pout_q, pout_d;

  logic [4:0]  addend;
  logic [5:0]  add_res;
  logic [10:0] shifted;

  // The single 5-bit ripple-carry adder; bit 5 of the result is the carry-out.
  function automatic logic [5:0] rca5(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] c;
    logic [4:0] s;
    c[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[5], s};
  endfunction

  // Partial product for this iteration and the shifted {Co,Sum,Q} result.
  always_comb begin
    addend  = q_q[0] ? m_q : 5'd0;
    add_res = rca5(acc_q, addend);
    shifted = {1'b0, add_res, q_q[4:1]};
  end

  // Next-state and datapath control; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pout_d  = pout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = Ain;
          q_d     = Bin;
          acc_d   = 5'd0;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = shifted[9:5];
        q_d   = shifted[4:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          pout_d  = shifted[9:0];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 5'd0;
      q_q     <= 5'd0;
      acc_q   <= 5'd0;
      cnt_q   <= 3'd0;
      pout_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    Pout = pout_q;
    busy = (state_q == RUN) || (state_q == DONE);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_my_mul5_seq.sv
// tb/tb_my_mul5_seq.sv - directed self-checking bench for my_mul5_seq
module tb_my_mul5_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] Ain;
  logic [4:0] Bin;
  logic [9:0] Pout;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  my_mul5_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Ain   (Ain),
    .Bin   (Bin),
    .Pout  (Pout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One start pulse, operands scrambled right after capture; samples on falling edges.
  task automatic do_op(input logic [4:0] a, input logic [4:0] b, input int exp,
                       input string tag, input bit timing);
    int ndone, nbusy, dcyc, nchg;
    logic [9:0] prev;
    prev = Pout;
    @(negedge clk);
    Ain = a; Bin = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; Ain = ~a; Bin = ~b;
    ndone = 0; nbusy = 0; dcyc = 0; nchg = 0;
    for (int i = 1; i <= 8; i++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; dcyc = i; end
      if (!done && busy && Pout != prev) nchg++;
      if (done) check({tag, "_pout"}, int'(Pout), exp);
      if (i < 8) @(negedge clk);
    end
    check({tag, "_ndone"}, ndone, 1);
    if (timing) begin
      check({tag, "_done_cyc"}, dcyc, 6);
      check({tag, "_nbusy"}, nbusy, 6);
      check({tag, "_pout_stable_run"}, nchg, 0);
      check({tag, "_idle_busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    int ndone, last, cyc;
    rst = 1'b1; start = 1'b0; Ain = 5'd0; Bin = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_pout", int'(Pout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    do_op(5'd31, 5'd31, 961, "m31x31", 1'b1);
    do_op(5'd21, 5'd10, 210, "m21x10", 1'b1);
    do_op(5'd0,  5'd17, 0,   "m0x17",  1'b1);
    do_op(5'd1,  5'd1,  1,   "m1x1",   1'b1);

    // Second start during RUN must be ignored.
    @(negedge clk);
    Ain = 5'd6; Bin = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    Ain = 5'd3; Bin = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin ndone++; check("ignore_pout", int'(Pout), 42); end
      @(negedge clk);
    end
    check("ignore_ndone", ndone, 1);
    check("ignore_idle", int'(busy), 0);

    // Reset mid-RUN aborts; start already high is accepted on the first edge after release.
    @(negedge clk);
    Ain = 5'd31; Bin = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_pout", int'(Pout), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    Ain = 5'd5; Bin = 5'd5; start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0; Ain = 5'd0; Bin = 5'd0;
    check("post_rst_accept", int'(busy), 1);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin ndone++; check("post_rst_pout", int'(Pout), 25); end
      @(negedge clk);
    end
    check("post_rst_ndone", ndone, 1);

    // Start held high: back-to-back operations every 7 cycles.
    @(negedge clk);
    Ain = 5'd12; Bin = 5'd19; start = 1'b1;
    ndone = 0; last = -1;
    for (cyc = 0; cyc < 29; cyc++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("held_pout", int'(Pout), 228);
        if (last >= 0) check("held_period", cyc - last, 7);
        last = cyc;
      end
    end
    check("held_ndone", ndone, 4);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Exhaustive operand sweep.
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        do_op(5'(a), 5'(b), a * b, "sweep", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
